// File: rtl/tilemap_pkg.sv
// rtl/tilemap_pkg.sv - shared register map, command codes, status bits and FSM states for the tilemap writer
package tilemap_pkg;

  localparam logic [2:0] REG_X     = 3'd0;
  localparam logic [2:0] REG_Y     = 3'd1;
  localparam logic [2:0] REG_W     = 3'd2;
  localparam logic [2:0] REG_H     = 3'd3;
  localparam logic [2:0] REG_VALUE = 3'd4;
  localparam logic [2:0] REG_CMD   = 3'd5;
  localparam logic [2:0] REG_DATA  = 3'd6;

  localparam logic [7:0] CMD_FILL   = 8'd1;
  localparam logic [7:0] CMD_STREAM = 8'd2;
  localparam logic [7:0] CMD_ABORT  = 8'd3;

  localparam int STAT_BUSY  = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;
  localparam int STAT_OVF   = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Cursor is 6 bits wide so columns/rows past 31 compare as out of bounds.
  function automatic logic cell_visible(input logic [5:0] col, input logic [5:0] row,
                                        input logic [4:0] cells_x, input logic [4:0] cells_y);
    return (col < {1'b0, cells_x}) && (row < {1'b0, cells_y});
  endfunction

endpackage

// File: rtl/tilemap_writer_fifo.sv
// rtl/tilemap_writer_fifo.sv - 8-bit synchronous FIFO holding CPU-pushed tile indices for STREAM
module tilemap_writer_fifo
  import tilemap_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] pop_data,
  output logic       full,
  output logic       empty
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  do_push, do_pop;

  assign full     = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
  assign empty    = (count_q == '0);
  // Full-drop is judged on the pre-pop occupancy.
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + (DEPTH_LOG2 + 1)'(do_push) - (DEPTH_LOG2 + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/tilemap_writer.sv
// rtl/tilemap_writer.sv - CPU-driven rectangle fill/stream writer for the tilemap index RAM
module tilemap_writer
  import tilemap_pkg::*;
#(
  parameter int         TILEMAP_RAM_WIDTH = 10,
  parameter logic [4:0] TILEMAP_CELLS_X   = 5'd22,
  parameter logic [4:0] TILEMAP_CELLS_Y   = 5'd17,
  parameter int         FIFO_DEPTH_LOG2   = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [2:0]                   addr,
  input  logic [7:0]                   data_in,
  input  logic                         write,
  output logic [7:0]                   data_out,
  input  logic                         hold,
  output logic                         busy,
  output logic [TILEMAP_RAM_WIDTH-1:0] tmram_addr,
  output logic [7:0]                   tmram_data_in,
  output logic                         tmram_wr
);

  logic [4:0] reg_x_q, reg_y_q, reg_w_q, reg_h_q;
  logic [7:0] reg_value_q;

  logic [1:0] state_q, state_d;
  logic       mode_fill_q, mode_fill_d;
  logic [4:0] x_s_q, x_s_d, w_s_q, w_s_d;
  logic [7:0] value_s_q, value_s_d;
  logic [5:0] col_q, col_d, row_q, row_d;
  logic [4:0] col_left_q, col_left_d, row_left_q, row_left_d;
  logic       overflow_q, overflow_d;
  logic       wr_q, wr_d;
  logic [TILEMAP_RAM_WIDTH-1:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;

  logic       cmd_wr, cmd_abort, cmd_start, data_push, issue, last_col, last_cell;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_data, status;

  assign cmd_wr    = write && (addr == REG_CMD);
  assign cmd_abort = cmd_wr && (data_in == CMD_ABORT);
  assign cmd_start = cmd_wr && (state_q == ST_IDLE) &&
                     ((data_in == CMD_FILL) || (data_in == CMD_STREAM));
  assign data_push = write && (addr == REG_DATA);
  assign issue     = (state_q == ST_RUN) && !cmd_abort && !hold && (mode_fill_q || !fifo_empty);
  assign last_col  = (col_left_q == 5'd1);
  assign last_cell = last_col && (row_left_q == 5'd1);
  assign busy      = (state_q != ST_IDLE);

  tilemap_writer_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (cmd_abort),
    .push      (data_push),
    .push_data (data_in),
    .pop       (issue && !mode_fill_q),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_x_q     <= '0;
      reg_y_q     <= '0;
      reg_w_q     <= '0;
      reg_h_q     <= '0;
      reg_value_q <= '0;
    end else if (write) begin
      case (addr)
        REG_X:     reg_x_q     <= data_in[4:0];
        REG_Y:     reg_y_q     <= data_in[4:0];
        REG_W:     reg_w_q     <= data_in[4:0];
        REG_H:     reg_h_q     <= data_in[4:0];
        REG_VALUE: reg_value_q <= data_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_fill_d = mode_fill_q;
    x_s_d       = x_s_q;
    w_s_d       = w_s_q;
    value_s_d   = value_s_q;
    col_d       = col_q;
    row_d       = row_q;
    col_left_d  = col_left_q;
    row_left_d  = row_left_q;
    overflow_d  = overflow_q || (data_push && fifo_full);
    wr_d        = 1'b0;
    addr_d      = addr_q;
    data_d      = data_q;
    if (cmd_abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_start) begin
            mode_fill_d = (data_in == CMD_FILL);
            x_s_d       = reg_x_q;
            w_s_d       = reg_w_q;
            value_s_d   = reg_value_q;
            col_d       = {1'b0, reg_x_q};
            row_d       = {1'b0, reg_y_q};
            col_left_d  = reg_w_q;
            row_left_d  = reg_h_q;
            overflow_d  = 1'b0;
            state_d     = (reg_w_q == '0 || reg_h_q == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            // Off-screen cells still burn their slot and stream byte, but stay off the bus.
            if (cell_visible(col_q, row_q, TILEMAP_CELLS_X, TILEMAP_CELLS_Y)) begin
              wr_d   = 1'b1;
              addr_d = TILEMAP_RAM_WIDTH'({row_q[4:0], col_q[4:0]});
              data_d = mode_fill_q ? value_s_q : fifo_data;
            end
            if (last_cell) begin
              state_d = ST_DONE;
            end else if (last_col) begin
              col_d      = {1'b0, x_s_q};
              row_d      = row_q + 6'd1;
              col_left_d = w_s_q;
              row_left_d = row_left_q - 5'd1;
            end else begin
              col_d      = col_q + 6'd1;
              col_left_d = col_left_q - 5'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mode_fill_q <= 1'b0;
      x_s_q       <= '0;
      w_s_q       <= '0;
      value_s_q   <= '0;
      col_q       <= '0;
      row_q       <= '0;
      col_left_q  <= '0;
      row_left_q  <= '0;
      overflow_q  <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      mode_fill_q <= mode_fill_d;
      x_s_q       <= x_s_d;
      w_s_q       <= w_s_d;
      value_s_q   <= value_s_d;
      col_q       <= col_d;
      row_q       <= row_d;
      col_left_q  <= col_left_d;
      row_left_q  <= row_left_d;
      overflow_q  <= overflow_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  assign tmram_wr      = wr_q;
  assign tmram_addr    = addr_q;
  assign tmram_data_in = data_q;

  always_comb begin
    status             = '0;
    status[STAT_BUSY]  = busy;
    status[STAT_FULL]  = fifo_full;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_OVF]   = overflow_q;
    case (addr)
      REG_X:     data_out = {3'b000, reg_x_q};
      REG_Y:     data_out = {3'b000, reg_y_q};
      REG_W:     data_out = {3'b000, reg_w_q};
      REG_H:     data_out = {3'b000, reg_h_q};
      REG_VALUE: data_out = reg_value_q;
      REG_CMD:   data_out = status;
      default:   data_out = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_tilemap_writer.sv
// tb/tb_tilemap_writer.sv - directed bench with a rectangle-walk reference model and per-strobe scoreboard
module tb_tilemap_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] addr = 3'd0;
  logic [7:0] data_in = 8'h00;
  logic       write = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] data_out;
  logic       busy;
  logic [9:0] tmram_addr;
  logic [7:0] tmram_data_in;
  logic       tmram_wr;

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
  } cell_t;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_strobe = 0;
  cell_t      exp_q[$];
  logic [7:0] stream_bytes[$];
  logic       hold_at_edge = 1'b0;

  tilemap_writer dut (
    .clk           (clk),
    .reset         (reset),
    .addr          (addr),
    .data_in       (data_in),
    .write         (write),
    .data_out      (data_out),
    .hold          (hold),
    .busy          (busy),
    .tmram_addr    (tmram_addr),
    .tmram_data_in (tmram_data_in),
    .tmram_wr      (tmram_wr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Row-major walk of the rectangle; only on-screen cells (22x17) produce a strobe.
  task automatic expect_rect(input int x, input int y, input int w, input int h,
                             input bit fill, input logic [7:0] val);
    cell_t c;
    for (int r = 0; r < h; r++) begin
      for (int k = 0; k < w; k++) begin
        c.a = 10'((y + r) * 32 + (x + k));
        c.d = fill ? val : stream_bytes[r * w + k];
        if ((x + k) < 22 && (y + r) < 17) exp_q.push_back(c);
      end
    end
  endtask

  always @(posedge clk) hold_at_edge <= hold;

  always @(negedge clk) begin
    if (hold_at_edge) check("strobe_under_hold", 32'(tmram_wr), 32'd0);
    if (tmram_wr) begin
      n_strobe++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe_addr", 32'(tmram_addr), 32'h3ff);
      end else begin
        check("strobe_addr", 32'(tmram_addr), 32'(exp_q[0].a));
        check("strobe_data", 32'(tmram_data_in), 32'(exp_q[0].d));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    addr = a;
    data_in = d;
    write = 1'b1;
    cyc();
    write = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [7:0] expv);
    addr = a;
    #1;
    check(name, 32'(data_out), 32'(expv));
  endtask

  task automatic cfg(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                     input logic [7:0] h, input logic [7:0] v);
    wr(3'd0, x);
    wr(3'd1, y);
    wr(3'd2, w);
    wr(3'd3, h);
    wr(3'd4, v);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      cyc();
      n++;
    end
    check("wait_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

  initial begin
    int s0;
    int cnt;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();

    // Reset state
    for (int i = 0; i < 8; i++) rd_check("reset_reg", 3'(i), (i == 5) ? 8'h20 : 8'h00);
    check("reset_wr", 32'(tmram_wr), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_addr", 32'(tmram_addr), 32'd0);

    // Plain fill 3x2 at (2,3)
    cfg(8'd2, 8'd3, 8'd3, 8'd2, 8'h41);
    expect_rect(2, 3, 3, 2, 1'b1, 8'h41);
    check("model_fill_size", 32'(exp_q.size()), 32'd6);
    check("model_fill_last", 32'(exp_q[5].a), 32'h084);
    s0 = n_strobe;
    wr(3'd5, 8'd1);
    check("fill_busy_n1", 32'(busy), 32'd1);
    check("fill_wr_n1", 32'(tmram_wr), 32'd0);
    cyc();
    check("fill_wr_n2", 32'(tmram_wr), 32'd1);
    check("fill_addr_n2", 32'(tmram_addr), 32'h062);
    check("fill_data_n2", 32'(tmram_data_in), 32'h41);
    repeat (5) cyc();
    check("fill_busy_n7", 32'(busy), 32'd1);
    check("fill_addr_n7", 32'(tmram_addr), 32'h084);
    cyc();
    check("fill_busy_n8", 32'(busy), 32'd0);
    check("fill_wr_n8", 32'(tmram_wr), 32'd0);
    check("fill_strobes", 32'(n_strobe - s0), 32'd6);
    check("fill_leftover", 32'(exp_q.size()), 32'd0);

    // Fill crossing the right and bottom edges
    cfg(8'd20, 8'd16, 8'd4, 8'd3, 8'h5a);
    expect_rect(20, 16, 4, 3, 1'b1, 8'h5a);
    check("model_clip_size", 32'(exp_q.size()), 32'd2);
    check("model_clip_first", 32'(exp_q[0].a), 32'h214);
    s0 = n_strobe;
    wr(3'd5, 8'd1);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      cyc();
    end
    check("clip_busy_cycles", 32'(cnt), 32'd13);
    check("clip_strobes", 32'(n_strobe - s0), 32'd2);
    check("clip_leftover", 32'(exp_q.size()), 32'd0);

    // Stream 4x1 at origin with gaps and hold pulses
    stream_bytes = '{8'haa, 8'hbb, 8'hcc, 8'hdd};
    cfg(8'd0, 8'd0, 8'd4, 8'd1, 8'h00);
    expect_rect(0, 0, 4, 1, 1'b0, 8'h00);
    s0 = n_strobe;
    wr(3'd5, 8'd2);
    repeat (3) cyc();
    hold = 1'b1;
    wr(3'd6, 8'haa);
    wr(3'd6, 8'hbb);
    cyc();
    rd_check("stream_status_held", 3'd5, 8'h80);
    hold = 1'b0;
    repeat (3) cyc();
    wr(3'd6, 8'hcc);
    hold = 1'b1;
    wr(3'd6, 8'hdd);
    cyc();
    hold = 1'b0;
    wait_idle();
    check("stream_strobes", 32'(n_strobe - s0), 32'd4);
    check("stream_leftover", 32'(exp_q.size()), 32'd0);
    rd_check("stream_status_end", 3'd5, 8'h20);

    // FIFO overflow while idle, cleared by the next FILL
    for (int i = 0; i < 9; i++) wr(3'd6, 8'(8'h10 + i));
    rd_check("ovf_status", 3'd5, 8'h50);
    cfg(8'd5, 8'd5, 8'd1, 8'd1, 8'h77);
    expect_rect(5, 5, 1, 1, 1'b1, 8'h77);
    check("model_single", 32'(exp_q[0].a), 32'h0a5);
    wr(3'd5, 8'd1);
    rd_check("ovf_cleared_busy", 3'd5, 8'hc0);
    wait_idle();
    rd_check("ovf_residue_kept", 3'd5, 8'h40);
    wr(3'd5, 8'd3);
    rd_check("idle_abort_flush", 3'd5, 8'h20);

    // ABORT after three of six cells
    cfg(8'd2, 8'd3, 8'd3, 8'd2, 8'h41);
    expect_rect(2, 3, 3, 2, 1'b1, 8'h41);
    s0 = n_strobe;
    wr(3'd5, 8'd1);
    wr(3'd6, 8'h99);
    wr(3'd6, 8'h98);
    cyc();
    wr(3'd5, 8'd3);
    check("abort_wr", 32'(tmram_wr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rd_check("abort_status", 3'd5, 8'h20);
    check("abort_remaining", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    repeat (4) cyc();
    check("abort_strobes", 32'(n_strobe - s0), 32'd3);

    // Same, but with a mid-operation reset
    cfg(8'd2, 8'd3, 8'd3, 8'd2, 8'h41);
    wr(3'd6, 8'h55);
    expect_rect(2, 3, 3, 2, 1'b1, 8'h41);
    s0 = n_strobe;
    wr(3'd5, 8'd1);
    repeat (3) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_wr", 32'(tmram_wr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_addr", 32'(tmram_addr), 32'd0);
    check("rst_data", 32'(tmram_data_in), 32'd0);
    for (int i = 0; i < 5; i++) rd_check("rst_reg", 3'(i), 8'h00);
    rd_check("rst_status", 3'd5, 8'h20);
    check("rst_remaining", 32'(exp_q.size()), 32'd3);
    exp_q.delete();
    check("rst_strobes", 32'(n_strobe - s0), 32'd3);

    // W=H=0 after reset: one DONE cycle, no writes
    s0 = n_strobe;
    wr(3'd5, 8'd1);
    check("empty_busy_n1", 32'(busy), 32'd1);
    cyc();
    check("empty_busy_n2", 32'(busy), 32'd0);
    repeat (2) cyc();
    check("empty_strobes", 32'(n_strobe - s0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
